// File: rtl/median_pkg.sv
`default_nettype none
// ============================================================================
// Module  : median_pkg
// Brief   : Shared limits, sideband token and compare-exchange helper.
// Rev     : 1.0  initial release
// ============================================================================
package median_pkg;

   localparam int c_min_window_size = 3;
   localparam int c_max_window_size = 9;
   localparam int c_max_data_width  = 32;

   typedef logic [c_max_data_width-1:0] sample_t;

   typedef struct packed {
      logic last;
      logic bypass;
      logic valid;
   } token_t;

   // True when the pair is out of order; caller moves min low, max high.
   function automatic logic cmp_exch_swap(input sample_t lo_in, input sample_t hi_in);
      return lo_in > hi_in;
   endfunction

   function automatic int median_index(input int window_size);
      return window_size / 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/median_filter_stream_if.sv
`default_nettype none
// ============================================================================
// Module  : median_filter_stream_if
// Brief   : Pixel in/out handshake bundle; MEDIAN_BYPASS_EN adds bypass.
// Rev     : 1.0  initial release
// ============================================================================
interface median_filter_stream_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CHANNELS   = 3
);
   logic                           in_valid;
   logic                           in_ready;
   logic [CHANNELS*DATA_WIDTH-1:0] in_data;
   logic                           in_last;
`ifdef MEDIAN_BYPASS_EN
   logic                           bypass;
`endif
   logic                           out_valid;
   logic                           out_ready;
   logic [CHANNELS*DATA_WIDTH-1:0] out_data;
   logic                           out_last;

   modport master (
      output in_valid,
      output in_data,
      output in_last,
`ifdef MEDIAN_BYPASS_EN
      output bypass,
`endif
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_last,
      output out_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
`ifdef MEDIAN_BYPASS_EN
      input  bypass,
`endif
      output in_ready,
      output out_valid,
      output out_data,
      output out_last,
      input  out_ready
   );
endinterface
`default_nettype wire

// File: rtl/median_sort_net.sv
`default_nettype none
// ============================================================================
// Module  : median_sort_net
// Brief   : Pipelined odd-even transposition sort of one channel's window.
// Rev     : 1.0  initial release
// ============================================================================
module median_sort_net
   import median_pkg::*;
#(
   parameter int WINDOW_SIZE = 3,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                                  clk,
   input  logic                                  en_i,
   input  logic [WINDOW_SIZE-1:0][DATA_WIDTH-1:0] win_i,
   output logic [DATA_WIDTH-1:0]                 median_o
);
   localparam int c_mid = median_index(WINDOW_SIZE);

   typedef logic [WINDOW_SIZE-1:0][DATA_WIDTH-1:0] vec_t;

   function automatic vec_t cx_layer(input vec_t v, input int first);
      vec_t r;
      r = v;
      for (int i = first; i + 1 < WINDOW_SIZE; i += 2) begin
         if (cmp_exch_swap(sample_t'(v[i]), sample_t'(v[i+1]))) begin
            r[i]   = v[i+1];
            r[i+1] = v[i];
         end
      end
      return r;
   endfunction

   vec_t stage_q [WINDOW_SIZE];
   vec_t stage_d [WINDOW_SIZE];

   // Stage s pairs from index s%2: even layers first, then odd, alternating.
   always_comb begin
      stage_d[0] = cx_layer(win_i, 0);
      for (int s = 1; s < WINDOW_SIZE; s++) begin
         stage_d[s] = cx_layer(stage_q[s-1], s % 2);
      end
   end

   always_ff @(posedge clk) begin
      if (en_i) begin
         for (int s = 0; s < WINDOW_SIZE; s++) begin
            stage_q[s] <= stage_d[s];
         end
      end
   end

   assign median_o = stage_q[WINDOW_SIZE-1][c_mid];

endmodule
`default_nettype wire

// File: rtl/median_filter_stream.sv
`default_nettype none
// ============================================================================
// Module  : median_filter_stream
// Brief   : Streaming multi-channel sliding-window median; MEDIAN_BYPASS_EN
//           selects the centre tap per token instead of the median.
// Rev     : 1.0  initial release
// ============================================================================
module median_filter_stream
   import median_pkg::*;
#(
   parameter int WINDOW_SIZE = 3,
   parameter int DATA_WIDTH  = 8,
   parameter int CHANNELS    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   median_filter_stream_if.slave strm
);
   localparam int                 c_mid   = median_index(WINDOW_SIZE);
   localparam int                 c_cnt_w = $clog2(WINDOW_SIZE + 1);
   localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(WINDOW_SIZE);

   typedef logic [CHANNELS-1:0][DATA_WIDTH-1:0] pixel_t;

   logic               advance;
   logic               accept;
   logic               issue;
   logic [c_cnt_w-1:0] fill_q;
   logic [c_cnt_w-1:0] fill_d;
   logic [c_cnt_w-1:0] fill_inc;
   token_t             tok_in;
   token_t             tok_q [WINDOW_SIZE];
   pixel_t             median;
   pixel_t             out_sel;
   logic               out_valid_q;
   logic               out_last_q;
   pixel_t             out_data_q;

   assign advance       = !(out_valid_q && !strm.out_ready);
   assign strm.in_ready = advance && !rst;
   assign accept        = strm.in_valid && strm.in_ready;

   always_comb begin
      fill_inc = (fill_q == c_full) ? fill_q : fill_q + c_cnt_w'(1);
      issue    = accept && (fill_inc == c_full);
      fill_d   = fill_q;
      if (accept) begin
         fill_d = strm.in_last ? '0 : fill_inc;
      end
   end

   always_comb begin
      tok_in       = '0;
      tok_in.valid = issue;
      tok_in.last  = strm.in_last;
`ifdef MEDIAN_BYPASS_EN
      tok_in.bypass = strm.bypass;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_q <= '0;
         for (int i = 0; i < WINDOW_SIZE; i++) begin
            tok_q[i] <= '0;
         end
      end else begin
         fill_q <= fill_d;
         if (advance) begin
            tok_q[0] <= tok_in;
            for (int i = 1; i < WINDOW_SIZE; i++) begin
               tok_q[i] <= tok_q[i-1];
            end
         end
      end
   end

`ifdef MEDIAN_BYPASS_EN
   pixel_t centre;
   pixel_t ctr_q [WINDOW_SIZE];
`endif

   generate
      for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
         logic [DATA_WIDTH-1:0]                  sample;
         logic [WINDOW_SIZE-2:0][DATA_WIDTH-1:0] hist_q;
         logic [WINDOW_SIZE-1:0][DATA_WIDTH-1:0] win;

         // win[0] is the sample being accepted; the oldest tap falls off the top.
         assign sample = strm.in_data[c*DATA_WIDTH +: DATA_WIDTH];
         assign win    = {hist_q, sample};

         always_ff @(posedge clk) begin
            if (rst) begin
               hist_q <= '0;
            end else if (accept) begin
               hist_q <= win[WINDOW_SIZE-2:0];
            end
         end

         median_sort_net #(
            .WINDOW_SIZE (WINDOW_SIZE),
            .DATA_WIDTH  (DATA_WIDTH)
         ) u_sort (
            .clk      (clk),
            .en_i     (advance),
            .win_i    (win),
            .median_o (median[c])
         );

`ifdef MEDIAN_BYPASS_EN
         assign centre[c] = win[c_mid];
`endif
      end
   endgenerate

`ifdef MEDIAN_BYPASS_EN
   // Centre tap rides alongside the sort network so both paths align.
   always_ff @(posedge clk) begin
      if (advance) begin
         ctr_q[0] <= centre;
         for (int i = 1; i < WINDOW_SIZE; i++) begin
            ctr_q[i] <= ctr_q[i-1];
         end
      end
   end

   assign out_sel = tok_q[WINDOW_SIZE-1].bypass ? ctr_q[WINDOW_SIZE-1] : median;
`else
   assign out_sel = median;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else if (advance) begin
         out_valid_q <= tok_q[WINDOW_SIZE-1].valid;
         out_last_q  <= tok_q[WINDOW_SIZE-1].valid && tok_q[WINDOW_SIZE-1].last;
         if (tok_q[WINDOW_SIZE-1].valid) begin
            out_data_q <= out_sel;
         end
      end
   end

   assign strm.out_valid = out_valid_q;
   assign strm.out_last  = out_last_q;
   assign strm.out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_median_filter_stream.sv
`default_nettype none
// ============================================================================
// Module  : tb_median_filter_stream
// Brief   : Self-checking bench with a queue-based median reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_median_filter_stream;
   localparam int W  = 3;
   localparam int DW = 8;
   localparam int CH = 3;
   localparam int PW = CH * DW;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   median_filter_stream_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) strm ();

   median_filter_stream #(
      .WINDOW_SIZE (W),
      .DATA_WIDTH  (DW),
      .CHANNELS    (CH)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .strm (strm.slave)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model state: current line samples (index 0 newest) and pending results.
   logic [PW-1:0] line_q [$];
   logic [PW-1:0] exp_data [$];
   logic          exp_last [$];
   int            exp_cyc [$];
   logic [PW-1:0] cap_data [$];
   logic          cap_last [$];
   int            cap_lat [$];
   int            vals [$];
   int            t_med;
   logic [PW-1:0] m_pix;
   logic          prev_stall = 1'b0;
   logic [PW-1:0] prev_data;
   logic          prev_last;

   int   ready_mode = 0;
   logic manual_ready = 1'b1;
   logic drv_bp = 1'b0;

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       strm.out_ready = 1'b1;
         1:       strm.out_ready = ($urandom_range(0, 3) != 0);
         default: strm.out_ready = manual_ready;
      endcase
   end

   always @(negedge clk) begin
      if (!rst) check_val("in_ready_term", 32'(strm.in_ready), 32'(!(strm.out_valid && !strm.out_ready)));
      else      check_val("in_ready_rst", 32'(strm.in_ready), 32'd0);

      if (prev_stall && !rst) begin
         check_val("hold_valid", 32'(strm.out_valid), 32'd1);
         check_val("hold_data", 32'(strm.out_data), 32'(prev_data));
         check_val("hold_last", 32'(strm.out_last), 32'(prev_last));
      end

      if (strm.out_valid && strm.out_ready) begin
         cap_data.push_back(strm.out_data);
         cap_last.push_back(strm.out_last);
         if (exp_data.size() == 0) begin
            check_val("out_without_expect", 32'(exp_data.size()), 32'd1);
         end else begin
            check_val("out_data", 32'(strm.out_data), 32'(exp_data.pop_front()));
            check_val("out_last", 32'(strm.out_last), 32'(exp_last.pop_front()));
            cap_lat.push_back(cyc - exp_cyc.pop_front());
         end
      end

      if (strm.in_valid && strm.in_ready) begin
         line_q.push_front(strm.in_data);
         if (line_q.size() > W) line_q.delete(W);
         if (line_q.size() == W) begin
            for (int c = 0; c < CH; c++) begin
               vals.delete();
               foreach (line_q[i]) vals.push_back(int'(line_q[i][c*DW +: DW]));
               vals.sort();
               t_med = vals[W/2];
               m_pix[c*DW +: DW] = t_med[DW-1:0];
            end
`ifdef MEDIAN_BYPASS_EN
            if (strm.bypass) m_pix = line_q[W/2];
`endif
            exp_data.push_back(m_pix);
            exp_last.push_back(strm.in_last);
            exp_cyc.push_back(cyc);
         end
         if (strm.in_last) line_q.delete();
      end

      if (rst) begin
         line_q.delete();
         exp_data.delete();
         exp_last.delete();
         exp_cyc.delete();
      end

      prev_stall = !rst && strm.out_valid && !strm.out_ready;
      prev_data  = strm.out_data;
      prev_last  = strm.out_last;
   end

   function automatic logic [PW-1:0] pix1(input logic [DW-1:0] v);
      return {v, v, v};
   endfunction

   task automatic send(input logic [PW-1:0] d, input logic l, input int gap);
      int   n;
      logic ok;
      strm.in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      strm.in_valid = 1'b1;
      strm.in_data  = d;
      strm.in_last  = l;
`ifdef MEDIAN_BYPASS_EN
      strm.bypass   = drv_bp;
`endif
      n = 0;
      forever begin
         @(negedge clk);
         ok = strm.in_ready;
         @(posedge clk);
         #1;
         if (ok) break;
         n++;
         if (n > 200) begin
            check_val("send_timeout", 32'(n), 32'd0);
            break;
         end
      end
      strm.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_data.size() != 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val("drain_pending", 32'(exp_data.size()), 32'd0);
      repeat (6) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_caps();
      cap_data.delete();
      cap_last.delete();
      cap_lat.delete();
   endtask

   task automatic check_cap(input string tag, input int idx, input logic [PW-1:0] d, input logic l);
      if (idx < cap_data.size()) begin
         check_val({tag, "_data"}, 32'(cap_data[idx]), 32'(d));
         check_val({tag, "_last"}, 32'(cap_last[idx]), 32'(l));
      end else begin
         check_val({tag, "_missing"}, 32'(cap_data.size()), 32'(idx + 1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      strm.in_valid = 1'b0;
      strm.in_data  = '0;
      strm.in_last  = 1'b0;
`ifdef MEDIAN_BYPASS_EN
      strm.bypass   = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_out_valid", 32'(strm.out_valid), 32'd0);
      check_val("rst_out_last", 32'(strm.out_last), 32'd0);
      check_val("rst_out_data", 32'(strm.out_data), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 5,1,9,3,7 -> 5,3,7 at four cycles per result
      clear_caps();
      send(pix1(8'd5), 1'b0, 0);
      send(pix1(8'd1), 1'b0, 0);
      send(pix1(8'd9), 1'b0, 0);
      send(pix1(8'd3), 1'b0, 0);
      send(pix1(8'd7), 1'b1, 0);
      drain();
      check_val("basic_count", 32'(cap_data.size()), 32'd3);
      check_cap("basic0", 0, pix1(8'd5), 1'b0);
      check_cap("basic1", 1, pix1(8'd3), 1'b0);
      check_cap("basic2", 2, pix1(8'd7), 1'b1);
      foreach (cap_lat[i]) check_val("latency", 32'(cap_lat[i]), 32'(W + 1));

      // Same stream with a multi-cycle downstream stall
      ready_mode   = 2;
      manual_ready = 1'b1;
      clear_caps();
      fork
         begin
            send(pix1(8'd5), 1'b0, 0);
            send(pix1(8'd1), 1'b0, 0);
            send(pix1(8'd9), 1'b0, 0);
            send(pix1(8'd3), 1'b0, 0);
            send(pix1(8'd7), 1'b1, 0);
         end
         begin
            int n;
            n = 0;
            while (!strm.out_valid && n < 50) begin
               @(posedge clk);
               #1;
               n++;
            end
            check_val("stall_first_valid", 32'(strm.out_valid), 32'd1);
            manual_ready = 1'b0;
            repeat (6) begin
               @(posedge clk);
               #1;
            end
            manual_ready = 1'b1;
         end
      join
      drain();
      ready_mode = 0;
      check_val("stall_count", 32'(cap_data.size()), 32'd3);
      check_cap("stall0", 0, pix1(8'd5), 1'b0);
      check_cap("stall1", 1, pix1(8'd3), 1'b0);
      check_cap("stall2", 2, pix1(8'd7), 1'b1);

      // Short line then a full line: no mixing across the boundary
      clear_caps();
      send(pix1(8'd2), 1'b0, 0);
      send(pix1(8'd8), 1'b1, 0);
      send(pix1(8'd4), 1'b0, 0);
      send(pix1(8'd6), 1'b0, 0);
      send(pix1(8'd1), 1'b1, 0);
      drain();
      check_val("line_count", 32'(cap_data.size()), 32'd1);
      check_cap("line0", 0, pix1(8'd4), 1'b1);

      // Independent per-channel medians, channel 0 in the LSBs
      clear_caps();
      send({8'd0,   8'd200, 8'd10}, 1'b0, 1);
      send({8'd255, 8'd100, 8'd30}, 1'b0, 0);
      send({8'd128, 8'd150, 8'd20}, 1'b1, 2);
      drain();
      check_val("rgb_count", 32'(cap_data.size()), 32'd1);
      check_cap("rgb0", 0, {8'd128, 8'd150, 8'd20}, 1'b1);

      // Reset with tokens in flight, then a fresh line
      clear_caps();
      send(pix1(8'd3), 1'b0, 0);
      send(pix1(8'd4), 1'b0, 0);
      send(pix1(8'd5), 1'b0, 0);
      send(pix1(8'd6), 1'b0, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_val("post_rst_valid", 32'(strm.out_valid), 32'd0);
      repeat (8) begin
         @(posedge clk);
         #1;
      end
      check_val("post_rst_quiet", 32'(cap_data.size()), 32'd0);
      send(pix1(8'd7), 1'b0, 0);
      send(pix1(8'd7), 1'b0, 0);
      send(pix1(8'd7), 1'b1, 0);
      drain();
      check_val("rst_count", 32'(cap_data.size()), 32'd1);
      check_cap("rst0", 0, pix1(8'd7), 1'b1);

`ifdef MEDIAN_BYPASS_EN
      clear_caps();
      send(pix1(8'd5), 1'b0, 0);
      send(pix1(8'd1), 1'b0, 0);
      drv_bp = 1'b1;
      send(pix1(8'd9), 1'b0, 0);
      drv_bp = 1'b0;
      send(pix1(8'd3), 1'b1, 0);
      drain();
      check_val("bp_count", 32'(cap_data.size()), 32'd2);
      check_cap("bp0", 0, pix1(8'd1), 1'b0);
      check_cap("bp1", 1, pix1(8'd3), 1'b1);
`endif

      // Random lines, random gaps, random back-pressure
      ready_mode = 1;
      for (int ln = 0; ln < 40; ln++) begin
         int len;
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++) begin
`ifdef MEDIAN_BYPASS_EN
            drv_bp = ($urandom_range(0, 3) == 0);
`endif
            send(PW'($urandom), (i == len - 1), $urandom_range(0, 2));
         end
      end
      drain();
      ready_mode = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
